// File: rtl/trigger_pulse_generator_pkg.sv
// Shared command definitions for the register interface, plus a small
// helper used when loading the pulse/gap length counters.
package trigger_pulse_generator_pkg;

  // Trigger pulse generator command codes
  localparam logic [7:0] TPG_CFG    = 8'h40;
  localparam logic [7:0] TPG_DELAY  = 8'h41;
  localparam logic [7:0] TPG_WIDTH  = 8'h42;
  localparam logic [7:0] TPG_GAP    = 8'h43;
  localparam logic [7:0] TPG_COUNT  = 8'h44;
  localparam logic [7:0] TPG_STATUS = 8'h45;

  localparam int TPG_DELAY_W = 32;
  localparam int TPG_LEN_W   = 16;

  // A programmed length of 0 behaves as 1; counters run down to zero, so
  // the load value is one less than the effective length.
  function automatic logic [TPG_LEN_W-1:0] tpg_len_minus_one(input logic [TPG_LEN_W-1:0] len);
    return (len == '0) ? '0 : len - TPG_LEN_W'(1);
  endfunction

endpackage

// File: rtl/trigger_pulse_generator_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is there.
module tpg_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             sampleclk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes priority over counting; counting stops at zero
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trigger_pulse_generator.sv
// Trigger pulse generator: after an armed trigger waits DELAY cycles, then
// emits COUNT+1 pulses of WIDTH cycles separated by GAP cycles.
module trigger_pulse_generator
  import trigger_pulse_generator_pkg::*;
(
  input  logic        sampleclk,
  input  logic        reset,
  input  logic        trigger_in,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  input  logic        reg_read,
  input  logic        reg_write,
  output logic        pulse_out,
  output logic        busy
);

  localparam int CFG_ARM      = 0;
  localparam int CFG_REARM    = 1;
  localparam int CFG_POLARITY = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } tpg_state_t;

  tpg_state_t state;

  logic [2:0]             cfg_reg;
  logic [TPG_DELAY_W-1:0] delay_reg;
  logic [TPG_LEN_W-1:0]   width_reg;
  logic [TPG_LEN_W-1:0]   gap_reg;
  logic [7:0]             count_reg;
  logic                   overrun;

  logic [TPG_LEN_W-1:0]   width_lat;
  logic [TPG_LEN_W-1:0]   gap_lat;
  logic [7:0]             pulses_left;

  logic wr_cfg, wr_delay, wr_width, wr_gap, wr_count, wr_status;
  logic [2:0] cfg_next;
  logic arm_next, pol_next;
  logic trigger_accept, burst_done, abort;

  logic                   delay_load, delay_en, delay_zero;
  logic [TPG_DELAY_W-1:0] delay_load_value;
  logic                   width_load, width_en, width_zero;
  logic [TPG_LEN_W-1:0]   width_load_value;
  logic                   gap_load, gap_en, gap_zero;
  logic [TPG_LEN_W-1:0]   gap_load_value;

  assign wr_cfg    = reg_write && (reg_cmd == TPG_CFG)    && (reg_bytecount == 16'd0);
  assign wr_delay  = reg_write && (reg_cmd == TPG_DELAY)  && (reg_bytecount < 16'd4);
  assign wr_width  = reg_write && (reg_cmd == TPG_WIDTH)  && (reg_bytecount < 16'd2);
  assign wr_gap    = reg_write && (reg_cmd == TPG_GAP)    && (reg_bytecount < 16'd2);
  assign wr_count  = reg_write && (reg_cmd == TPG_COUNT)  && (reg_bytecount == 16'd0);
  assign wr_status = reg_write && (reg_cmd == TPG_STATUS) && (reg_bytecount == 16'd0);

  // The configuration as it will be after this edge's write (if any)
  assign cfg_next = wr_cfg ? reg_data_in[2:0] : cfg_reg;
  assign arm_next = cfg_next[CFG_ARM];
  assign pol_next = cfg_next[CFG_POLARITY];

  assign busy           = (state == ST_DELAY) || (state == ST_PULSE) || (state == ST_GAP);
  assign trigger_accept = (state == ST_ARMED) && cfg_reg[CFG_ARM] && trigger_in;
  assign abort          = busy && !arm_next;
  assign burst_done     = (state == ST_PULSE) && width_zero && (pulses_left == 8'd0);

  assign delay_load       = trigger_accept;
  assign delay_load_value = (delay_reg == '0) ? '0 : delay_reg - TPG_DELAY_W'(1);
  assign delay_en         = (state == ST_DELAY);

  assign width_load = (trigger_accept && (delay_reg == '0)) ||
                      ((state == ST_DELAY) && delay_zero) ||
                      ((state == ST_GAP) && gap_zero);
  assign width_load_value = trigger_accept ? tpg_len_minus_one(width_reg)
                                           : tpg_len_minus_one(width_lat);
  assign width_en = (state == ST_PULSE);

  assign gap_load       = (state == ST_PULSE) && width_zero && (pulses_left != 8'd0);
  assign gap_load_value = tpg_len_minus_one(gap_lat);
  assign gap_en         = (state == ST_GAP);

  tpg_down_counter #(.WIDTH(TPG_DELAY_W)) u_delay_counter (
    .sampleclk  (sampleclk),
    .reset      (reset),
    .load       (delay_load),
    .load_value (delay_load_value),
    .enable     (delay_en),
    .zero       (delay_zero)
  );

  tpg_down_counter #(.WIDTH(TPG_LEN_W)) u_width_counter (
    .sampleclk  (sampleclk),
    .reset      (reset),
    .load       (width_load),
    .load_value (width_load_value),
    .enable     (width_en),
    .zero       (width_zero)
  );

  tpg_down_counter #(.WIDTH(TPG_LEN_W)) u_gap_counter (
    .sampleclk  (sampleclk),
    .reset      (reset),
    .load       (gap_load),
    .load_value (gap_load_value),
    .enable     (gap_en),
    .zero       (gap_zero)
  );

  // Register file writes, ARM self-clear at burst end, sticky overrun flag
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      cfg_reg   <= '0;
      delay_reg <= '0;
      width_reg <= '0;
      gap_reg   <= '0;
      count_reg <= '0;
      overrun   <= 1'b0;
    end else begin
      if (wr_cfg) begin
        cfg_reg <= reg_data_in[2:0];
      end else if (burst_done && !cfg_reg[CFG_REARM]) begin
        cfg_reg[CFG_ARM] <= 1'b0;
      end
      if (wr_delay) begin
        case (reg_bytecount[1:0])
          2'd0:    delay_reg[7:0]   <= reg_data_in;
          2'd1:    delay_reg[15:8]  <= reg_data_in;
          2'd2:    delay_reg[23:16] <= reg_data_in;
          default: delay_reg[31:24] <= reg_data_in;
        endcase
      end
      if (wr_width) begin
        if (reg_bytecount[0]) width_reg[15:8] <= reg_data_in;
        else                  width_reg[7:0]  <= reg_data_in;
      end
      if (wr_gap) begin
        if (reg_bytecount[0]) gap_reg[15:8] <= reg_data_in;
        else                  gap_reg[7:0]  <= reg_data_in;
      end
      if (wr_count) begin
        count_reg <= reg_data_in;
      end
      if (busy && trigger_in) begin
        overrun <= 1'b1;
      end else if (wr_status) begin
        overrun <= 1'b0;
      end
    end
  end

  // Burst sequencer; pulse_out is registered alongside the state it reflects
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pulse_out   <= 1'b0;
      width_lat   <= '0;
      gap_lat     <= '0;
      pulses_left <= '0;
    end else begin
      pulse_out <= pol_next;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_reg[CFG_ARM]) state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (!cfg_reg[CFG_ARM]) begin
              state <= ST_IDLE;
            end else if (trigger_in) begin
              width_lat   <= width_reg;
              gap_lat     <= gap_reg;
              pulses_left <= count_reg;
              if (delay_reg == '0) begin
                state     <= ST_PULSE;
                pulse_out <= ~pol_next;
              end else begin
                state <= ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (delay_zero) begin
              state     <= ST_PULSE;
              pulse_out <= ~pol_next;
            end
          end
          ST_PULSE: begin
            if (width_zero) begin
              if (pulses_left != 8'd0) begin
                state       <= ST_GAP;
                pulses_left <= pulses_left - 8'd1;
              end else if (cfg_reg[CFG_REARM]) begin
                state <= ST_ARMED;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              pulse_out <= ~pol_next;
            end
          end
          ST_GAP: begin
            if (gap_zero) begin
              state     <= ST_PULSE;
              pulse_out <= ~pol_next;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Combinational read-back; undefined commands and byte indices read 0
  always_comb begin
    reg_data_out = 8'h00;
    if (reg_read) begin
      case (reg_cmd)
        TPG_CFG: begin
          if (reg_bytecount == 16'd0) reg_data_out = {5'b00000, cfg_reg};
        end
        TPG_DELAY: begin
          case (reg_bytecount)
            16'd0:   reg_data_out = delay_reg[7:0];
            16'd1:   reg_data_out = delay_reg[15:8];
            16'd2:   reg_data_out = delay_reg[23:16];
            16'd3:   reg_data_out = delay_reg[31:24];
            default: reg_data_out = 8'h00;
          endcase
        end
        TPG_WIDTH: begin
          if (reg_bytecount == 16'd0)      reg_data_out = width_reg[7:0];
          else if (reg_bytecount == 16'd1) reg_data_out = width_reg[15:8];
        end
        TPG_GAP: begin
          if (reg_bytecount == 16'd0)      reg_data_out = gap_reg[7:0];
          else if (reg_bytecount == 16'd1) reg_data_out = gap_reg[15:8];
        end
        TPG_COUNT: begin
          if (reg_bytecount == 16'd0) reg_data_out = count_reg;
        end
        TPG_STATUS: begin
          if (reg_bytecount == 16'd0) reg_data_out = {3'b000, overrun, busy, state};
        end
        default: reg_data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Self-checking bench for trigger_pulse_generator: register map table plus
// hand-written burst sequences compared cycle by cycle against a queue.
module tb_trigger_pulse_generator;
  import trigger_pulse_generator_pkg::*;

  logic        sampleclk = 1'b0;
  logic        reset;
  logic        trigger_in;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;
  logic        pulse_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] readQ[$];
  logic       pulseQ[$];

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [15:0] bc;
    logic        doWrite;
    logic [7:0]  wdata;
    logic [7:0]  expRead;
  } regVec_t;

  regVec_t vecs[$];

  trigger_pulse_generator dut (
    .sampleclk     (sampleclk),
    .reset         (reset),
    .trigger_in    (trigger_in),
    .reg_cmd       (reg_cmd),
    .reg_bytecount (reg_bytecount),
    .reg_data_in   (reg_data_in),
    .reg_data_out  (reg_data_out),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .pulse_out     (pulse_out),
    .busy          (busy)
  );

  // Free-running sample clock
  always #5 sampleclk = ~sampleclk;

  // Guard against a run that never finishes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge sampleclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] data);
    reg_cmd       = cmd;
    reg_bytecount = bc;
    reg_data_in   = data;
    reg_write     = 1'b1;
    tick();
    reg_write     = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] cmd, input logic [15:0] bc, output logic [7:0] data);
    reg_cmd       = cmd;
    reg_bytecount = bc;
    reg_read      = 1'b1;
    #1;
    data          = reg_data_out;
    reg_read      = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] expected);
    logic [7:0] got;
    readQ.push_back(expected);
    readReg(cmd, bc, got);
    checkOutput(name, got, readQ.pop_front());
  endtask

  task automatic writeField(input logic [7:0] cmd, input int nbytes, input logic [31:0] value);
    for (int b = 0; b < nbytes; b++) begin
      writeReg(cmd, 16'(b), value[8*b +: 8]);
    end
  endtask

  task automatic configure(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g, input logic [31:0] c);
    writeField(TPG_DELAY, 4, d);
    writeField(TPG_WIDTH, 2, w);
    writeField(TPG_GAP,   2, g);
    writeField(TPG_COUNT, 1, c);
  endtask

  // Write CFG, let the block reach ARMED, then trigger for one edge
  task automatic armAndTrigger(input logic [7:0] cfg);
    writeReg(TPG_CFG, 16'd0, cfg);
    tick();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
  endtask

  // Reference burst: index 0 is the value observed just after the trigger edge
  task automatic pushTrain(input int d, input int w, input int g, input int c, input logic pol, input int tail);
    int wl;
    int gl;
    wl = (w == 0) ? 1 : w;
    gl = (g == 0) ? 1 : g;
    for (int j = 0; j < d; j++) pulseQ.push_back(pol);
    for (int p = 0; p <= c; p++) begin
      for (int i = 0; i < wl; i++) pulseQ.push_back(!pol);
      if (p != c) begin
        for (int i = 0; i < gl; i++) pulseQ.push_back(pol);
      end
    end
    for (int j = 0; j < tail; j++) pulseQ.push_back(pol);
  endtask

  task automatic runTrain(input string name, input int retrigAt);
    int j;
    logic e;
    j = 0;
    while (pulseQ.size() > 0) begin
      e = pulseQ.pop_front();
      checkOutput(name, pulse_out, e);
      trigger_in = (j == retrigAt);
      tick();
      j++;
    end
    trigger_in = 1'b0;
  endtask

  task automatic addVec(input string name, input logic [7:0] cmd, input logic [15:0] bc,
                        input logic doWrite, input logic [7:0] wdata, input logic [7:0] expRead);
    regVec_t v;
    v.name    = name;
    v.cmd     = cmd;
    v.bc      = bc;
    v.doWrite = doWrite;
    v.wdata   = wdata;
    v.expRead = expRead;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input regVec_t v);
    if (v.doWrite) writeReg(v.cmd, v.bc, v.wdata);
    readQ.push_back(v.expRead);
  endtask

  initial begin
    logic [7:0] got;
    int highs;

    reset = 1'b1; trigger_in = 1'b0; reg_cmd = '0; reg_bytecount = '0;
    reg_data_in = '0; reg_read = 1'b0; reg_write = 1'b0;

    addVec("cfg_reserved", TPG_CFG,    16'd0, 1'b1, 8'hFE, 8'h06);
    addVec("delay_b0",     TPG_DELAY,  16'd0, 1'b1, 8'h11, 8'h11);
    addVec("delay_b1",     TPG_DELAY,  16'd1, 1'b1, 8'h22, 8'h22);
    addVec("delay_b2",     TPG_DELAY,  16'd2, 1'b1, 8'h33, 8'h33);
    addVec("delay_b3",     TPG_DELAY,  16'd3, 1'b1, 8'h44, 8'h44);
    addVec("delay_b4_bad", TPG_DELAY,  16'd4, 1'b1, 8'h55, 8'h00);
    addVec("delay_b0_kept",TPG_DELAY,  16'd0, 1'b0, 8'h00, 8'h11);
    addVec("width_b0",     TPG_WIDTH,  16'd0, 1'b1, 8'hA5, 8'hA5);
    addVec("width_b1",     TPG_WIDTH,  16'd1, 1'b1, 8'h5A, 8'h5A);
    addVec("width_b2_bad", TPG_WIDTH,  16'd2, 1'b1, 8'h77, 8'h00);
    addVec("gap_b0",       TPG_GAP,    16'd0, 1'b1, 8'h3C, 8'h3C);
    addVec("gap_b1",       TPG_GAP,    16'd1, 1'b1, 8'hC3, 8'hC3);
    addVec("count_b0",     TPG_COUNT,  16'd0, 1'b1, 8'h81, 8'h81);
    addVec("count_b1_bad", TPG_COUNT,  16'd1, 1'b1, 8'h99, 8'h00);
    addVec("status_ro",    TPG_STATUS, 16'd0, 1'b1, 8'hFF, 8'h00);
    addVec("bad_cmd",      8'hEE,      16'd0, 1'b1, 8'h99, 8'h00);
    addVec("cfg_clear",    TPG_CFG,    16'd0, 1'b1, 8'h00, 8'h00);

    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_pulse_out", pulse_out, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkRead("rst_status", TPG_STATUS, 16'd0, 8'h00);
    checkRead("rst_cfg", TPG_CFG, 16'd0, 8'h00);

    $display("[TB] trigger while idle is ignored");
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    tick();
    checkOutput("idle_trig_busy", busy, 1'b0);
    checkRead("idle_trig_status", TPG_STATUS, 16'd0, 8'h00);

    $display("[TB] register map table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      readReg(vecs[i].cmd, vecs[i].bc, got);
      checkOutput(vecs[i].name, got, readQ.pop_front());
      tick();
    end

    reg_cmd = TPG_DELAY; reg_bytecount = 16'd0; reg_read = 1'b0;
    #1;
    checkOutput("read_low_zero", reg_data_out, 8'h00);
    tick();

    $display("[TB] single pulse after delay 5");
    configure(32'd5, 32'd3, 32'd0, 32'd0);
    armAndTrigger(8'h01);
    checkRead("single_status_delay", TPG_STATUS, 16'd0, 8'h0A);
    pushTrain(5, 3, 0, 0, 1'b0, 3);
    runTrain("single_train", -1);
    checkRead("single_arm_cleared", TPG_CFG, 16'd0, 8'h00);
    checkRead("single_status_idle", TPG_STATUS, 16'd0, 8'h00);

    $display("[TB] zero-delay burst of three with rearm");
    configure(32'd0, 32'd2, 32'd4, 32'd2);
    armAndTrigger(8'h03);
    pushTrain(0, 2, 4, 2, 1'b0, 2);
    runTrain("burst3_train", -1);
    checkRead("burst3_status_armed", TPG_STATUS, 16'd0, 8'h01);
    checkRead("burst3_cfg_kept", TPG_CFG, 16'd0, 8'h03);
    writeReg(TPG_CFG, 16'd0, 8'h00);
    tick();
    checkRead("disarm_status", TPG_STATUS, 16'd0, 8'h00);

    $display("[TB] retrigger during delay");
    configure(32'd20, 32'd1, 32'd0, 32'd0);
    armAndTrigger(8'h01);
    pushTrain(20, 1, 0, 0, 1'b0, 25);
    runTrain("retrig_train", 3);
    checkRead("retrig_overrun", TPG_STATUS, 16'd0, 8'h10);
    writeReg(TPG_STATUS, 16'd0, 8'h00);
    checkRead("retrig_overrun_clr", TPG_STATUS, 16'd0, 8'h00);

    $display("[TB] abort mid-pulse");
    configure(32'd0, 32'd10, 32'd0, 32'd0);
    armAndTrigger(8'h01);
    checkOutput("abort_pulse_start", pulse_out, 1'b1);
    tick();
    tick();
    checkOutput("abort_pulse_mid", pulse_out, 1'b1);
    writeReg(TPG_CFG, 16'd0, 8'h00);
    checkOutput("abort_pulse_off", pulse_out, 1'b0);
    checkRead("abort_status", TPG_STATUS, 16'd0, 8'h00);
    tick();
    checkOutput("abort_stays_off", pulse_out, 1'b0);

    $display("[TB] inverted polarity, zero width");
    configure(32'd2, 32'd0, 32'd0, 32'd0);
    armAndTrigger(8'h05);
    pushTrain(2, 0, 0, 0, 1'b1, 3);
    runTrain("pol_train", -1);
    writeReg(TPG_CFG, 16'd0, 8'h00);
    checkOutput("pol_restored", pulse_out, 1'b0);

    $display("[TB] multi-byte delay 258");
    configure(32'h0000_0102, 32'd1, 32'd0, 32'd0);
    armAndTrigger(8'h01);
    pushTrain(258, 1, 0, 0, 1'b0, 2);
    runTrain("delay258_train", -1);

    $display("[TB] count 255 gives 256 pulses");
    configure(32'd1, 32'd1, 32'd1, 32'd255);
    armAndTrigger(8'h01);
    pushTrain(1, 1, 1, 255, 1'b0, 3);
    runTrain("count255_train", -1);
    checkRead("count255_arm_cleared", TPG_CFG, 16'd0, 8'h00);

    $display("[TB] reset during gap");
    configure(32'd0, 32'd2, 32'd5, 32'd3);
    armAndTrigger(8'h03);
    tick();
    tick();
    tick();
    checkRead("gap_status", TPG_STATUS, 16'd0, 8'h0C);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (pulse_out !== 1'b0 || busy !== 1'b0) highs++;
      tick();
    end
    checkOutput("post_reset_quiet", 32'(highs), 32'd0);
    checkRead("post_reset_cfg", TPG_CFG, 16'd0, 8'h00);
    tick();
    for (int b = 0; b < 4; b++) begin
      checkRead("post_reset_delay", TPG_DELAY, 16'(b), 8'h00);
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      checkRead("post_reset_width", TPG_WIDTH, 16'(b), 8'h00);
      checkRead("post_reset_gap", TPG_GAP, 16'(b), 8'h00);
      tick();
    end
    checkRead("post_reset_count", TPG_COUNT, 16'd0, 8'h00);
    checkRead("post_reset_status", TPG_STATUS, 16'd0, 8'h00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
